// File: rtl/usr_idata_pingpong_ram.sv
// Double-buffered input-data RAM: the producer fills and commits one bank while
// the consumer reads and releases the other. Bank ownership and error flags are built in.
`timescale 1ns/1ps
module usr_idata_pingpong_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_commit,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_release,
    output logic              rd_ready,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic [1:0]        level,
    output logic              err_wr,
    output logic              err_rd
);

    localparam int DEPTH = 2 ** (ADDR_W + 1);

    logic [1:0]        full;
    logic              wr_acc;
    logic              commit_acc;
    logic              rd_acc;
    logic              release_acc;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_s1;
    logic              rd_valid_s1;

    assign wr_ready    = !full[wr_bank];
    assign rd_ready    = full[rd_bank];
    assign level       = {1'b0, full[0]} + {1'b0, full[1]};

    assign wr_acc      = wr_en      & wr_ready;
    assign commit_acc  = wr_commit  & wr_ready;
    assign rd_acc      = rd_en      & rd_ready;
    assign release_acc = rd_release & rd_ready;

    // Commit and release always hit different banks: a writable bank is empty
    // and a readable bank is full, so both bit updates of full can coexist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            err_wr  <= 1'b0;
            err_rd  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // condition above sees the pre-edge values of full and the pointers.
            if (commit_acc) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (release_acc) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            if ((wr_en | wr_commit) & !wr_ready) err_wr <= 1'b1;
            if ((rd_en | rd_release) & !rd_ready) err_rd <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset so it maps onto block RAM; only the
    // read pipeline registers below are reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[{wr_bank, wr_addr}] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_s1  <= '0;
            rd_valid_s1 <= 1'b0;
        end else begin
            rd_valid_s1 <= rd_acc;
            if (rd_acc) rd_data_s1 <= mem[{rd_bank, rd_addr}];
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] rd_data_s2;
        logic              rd_valid_s2;

        // Output register loads only on a valid beat so rd_data holds between reads.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_s2  <= '0;
                rd_valid_s2 <= 1'b0;
            end else begin
                rd_valid_s2 <= rd_valid_s1;
                if (rd_valid_s1) rd_data_s2 <= rd_data_s1;
            end
        end

        assign rd_data  = rd_data_s2;
        assign rd_valid = rd_valid_s2;
    end else begin : g_lat1
        assign rd_data  = rd_data_s1;
        assign rd_valid = rd_valid_s1;
    end

endmodule

// File: tb/tb_usr_idata_pingpong_ram.sv
// Scoreboard bench: one stimulus stream drives an RD_LAT=1 and an RD_LAT=2 instance,
// checked against a bank-level model of the ping-pong buffer.
`timescale 1ns/1ps
module tb_usr_idata_pingpong_ram;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int WORDS  = 1 << ADDR_W;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                issue;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_commit = 1'b0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_release = 1'b0;

    logic [1:0]        wr_ready_v, rd_ready_v, rd_valid_v, wr_bank_v, rd_bank_v, err_wr_v, err_rd_v;
    logic [DATA_W-1:0] rd_data_v [2];
    logic [1:0]        level_v [2];

    // Reference model: two banks of words, a full flag per bank, owner pointers.
    logic [DATA_W-1:0] m_mem [2*WORDS];
    bit                m_known [2*WORDS];
    bit   [1:0]        m_full = 2'b00;
    int                m_wb = 0;
    int                m_rb = 0;
    bit                m_errw = 1'b0;
    bit                m_errr = 1'b0;

    exp_t              exp_q[$];
    int                head [2] = '{0, 0};
    logic [DATA_W-1:0] last_data [2] = '{'0, '0};
    int                cyc = 0;
    int                checks = 0;
    int                failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    usr_idata_pingpong_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
        .wr_ready(wr_ready_v[0]),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_v[0]), .rd_valid(rd_valid_v[0]),
        .rd_release(rd_release), .rd_ready(rd_ready_v[0]),
        .wr_bank(wr_bank_v[0]), .rd_bank(rd_bank_v[0]), .level(level_v[0]),
        .err_wr(err_wr_v[0]), .err_rd(err_rd_v[0])
    );

    usr_idata_pingpong_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
        .wr_ready(wr_ready_v[1]),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_v[1]), .rd_valid(rd_valid_v[1]),
        .rd_release(rd_release), .rd_ready(rd_ready_v[1]),
        .wr_bank(wr_bank_v[1]), .rd_bank(rd_bank_v[1]), .level(level_v[1]),
        .err_wr(err_wr_v[1]), .err_rd(err_rd_v[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [7:0] model_status();
        int lvl = int'(m_full[0]) + int'(m_full[1]);
        return {~m_full[m_wb], m_full[m_rb], lvl[1:0], m_wb[0], m_rb[0], m_errw, m_errr};
    endfunction

    function automatic logic [7:0] dut_status(input int k);
        return {wr_ready_v[k], rd_ready_v[k], level_v[k], wr_bank_v[k], rd_bank_v[k],
                err_wr_v[k], err_rd_v[k]};
    endfunction

    // One clock cycle: drive, compare status at the falling edge, advance the model.
    task automatic step(input bit we, input int wa, input logic [DATA_W-1:0] wd, input bit wc,
                        input bit re, input int ra, input bit rr);
        exp_t e;
        bit   wok;
        bit   rok;
        int   wb;
        int   rb;
        wr_en      = we;
        wr_addr    = wa[ADDR_W-1:0];
        wr_data    = wd;
        wr_commit  = wc;
        rd_en      = re;
        rd_addr    = ra[ADDR_W-1:0];
        rd_release = rr;
        @(negedge clk);
        check("status_lat1", dut_status(0), model_status());
        check("status_lat2", dut_status(1), model_status());
        wok = !m_full[m_wb];
        rok = m_full[m_rb];
        wb  = m_wb;
        rb  = m_rb;
        if (re) begin
            if (rok) begin
                e.data  = m_mem[rb*WORDS + ra];
                e.issue = cyc;
                exp_q.push_back(e);
            end else m_errr = 1'b1;
        end
        if (we) begin
            if (wok) begin
                m_mem[wb*WORDS + wa]   = wd;
                m_known[wb*WORDS + wa] = 1'b1;
            end else m_errw = 1'b1;
        end
        if (wc) begin
            if (wok) begin
                m_full[wb] = 1'b1;
                m_wb       = 1 - wb;
            end else m_errw = 1'b1;
        end
        if (rr) begin
            if (rok) begin
                m_full[rb] = 1'b0;
                m_rb       = 1 - rb;
            end else m_errr = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        m_full = 2'b00;
        m_wb   = 0;
        m_rb   = 0;
        m_errw = 1'b0;
        m_errr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            head[k]      = exp_q.size();
            last_data[k] = '0;
        end
    endtask

    task automatic check_reset_values();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_status_lat%0d", k + 1), dut_status(k), model_status());
            check($sformatf("rst_rd_valid_lat%0d", k + 1), rd_valid_v[k], 1'b0);
            check($sformatf("rst_rd_data_lat%0d", k + 1), rd_data_v[k], '0);
        end
    endtask

    // Asserts reset part-way through a cycle, then releases it on a falling edge.
    task automatic mid_stream_reset();
        wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++)
            check($sformatf("rd_valid_after_rst_lat%0d", k + 1), rd_valid_v[k], 1'b0);
    endtask

    task automatic pick_read_addr(output bit ok, output int a);
        ok = 1'b0;
        a  = 0;
        for (int t = 0; t < 32 && !ok; t++) begin
            a = $urandom_range(0, WORDS - 1);
            ok = m_known[m_rb*WORDS + a];
        end
    endtask

    // Scoreboard monitor: pops one expected word per rd_valid pulse.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (rd_valid_v[k]) begin
                    if (head[k] >= exp_q.size()) begin
                        check($sformatf("rd_extra_lat%0d", k + 1), rd_valid_v[k], 1'b0);
                    end else begin
                        e = exp_q[head[k]];
                        head[k]++;
                        check($sformatf("rd_data_lat%0d", k + 1), rd_data_v[k], e.data);
                        check($sformatf("rd_latency_lat%0d", k + 1), cyc - e.issue, k + 1);
                        last_data[k] = e.data;
                    end
                end else begin
                    check($sformatf("rd_hold_lat%0d", k + 1), rd_data_v[k], last_data[k]);
                    if (head[k] < exp_q.size() && cyc - exp_q[head[k]].issue > k + 1) begin
                        check($sformatf("rd_missing_lat%0d", k + 1), rd_valid_v[k], 1'b1);
                        head[k]++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit ok;
        int a;
        bit re;
        // Power-on reset.
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill bank 0 with a known pattern, commit on the last write.
        for (int i = 0; i < WORDS; i++) step(1, i, 32'hA000_0000 + i, i == WORDS - 1, 0, 0, 0);
        // Drain it back-to-back, releasing together with the last read.
        for (int i = 0; i < WORDS; i++) step(0, 0, '0, 0, 1, i, i == WORDS - 1);
        idle(3);

        // Reads in flight from bank 1 when reset hits.
        for (int i = 0; i < 8; i++) step(1, i, $urandom, i == 7, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 1, i, 0);
        mid_stream_reset();

        // Ping-pong overlap: commit bank 0, write bank 1 while reading bank 0.
        for (int i = 0; i < 16; i++) step(1, $urandom_range(0, WORDS - 1), $urandom, i == 15, 0, 0, 0);
        step(1, 5, $urandom, 0, 1, $urandom_range(0, WORDS - 1), 0);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1), $urandom_range(0, WORDS - 1), $urandom, i == 299,
                 $urandom_range(0, 1), $urandom_range(0, WORDS - 1), i == 299);
        idle(2);

        // Both banks full; a write and a commit while full must be refused.
        step(1, 5, $urandom, 1, 0, 0, 0);
        step(1, 5, 32'h0000_DEAD, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0);
        idle(1);
        step(0, 0, '0, 0, 1, 5, 1);
        step(0, 0, '0, 0, 1, 5, 1);
        idle(3);

        // Empty read and release.
        step(0, 0, '0, 0, 1, 7, 1);
        idle(4);

        // Mixed random traffic, including occasional protocol violations.
        for (int i = 0; i < 2000; i++) begin
            if (m_full[m_rb]) begin
                pick_read_addr(ok, a);
                re = ok && ($urandom_range(0, 1) == 1);
            end else begin
                a  = $urandom_range(0, WORDS - 1);
                re = ($urandom_range(0, 7) == 0);
            end
            step($urandom_range(0, 1), $urandom_range(0, WORDS - 1), $urandom,
                 $urandom_range(0, 15) == 0, re, a, $urandom_range(0, 15) == 0);
        end
        idle(5);

        for (int k = 0; k < 2; k++)
            check($sformatf("drain_lat%0d", k + 1), head[k], exp_q.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usr_idata_pingpong_ram.md
# usr_idata_pingpong_ram

Parametrised, single-clock, double-buffered (ping-pong) input-data RAM. It supersedes the fixed 32x1024 simple dual-port input buffer. A producer fills one bank and commits it, while a consumer reads the other, previously committed bank and then releases it. Bank ownership, full/empty tracking, a selectable read latency and sticky protocol-error flags are built into the block. It sits between the input-data capture logic and the processing core.

## Interface
Parameters:
- DATA_W, 32, data word width in bits (>=1).
- ADDR_W, 10, per-bank address width; each bank holds 2^ADDR_W words, 2*2^ADDR_W words in total.
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write wr_data at wr_addr in the current write bank.
- wr_addr  in  ADDR_W  write address within the bank.
- wr_data  in  DATA_W  write data.
- wr_commit  in  1  marks the write bank full and hands it to the reader.
- wr_ready  out  1  current write bank is empty and writable.
- rd_en  in  1  read rd_addr from the current read bank.
- rd_addr  in  ADDR_W  read address within the bank.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data holds the result of an accepted read.
- rd_release  in  1  frees the current read bank.
- rd_ready  out  1  current read bank is full and readable.
- wr_bank  out  1  index of the current write bank.
- rd_bank  out  1  index of the current read bank.
- level  out  2  number of full banks (0..2).
- err_wr  out  1  sticky flag: write or commit attempted while wr_ready=0.
- err_rd  out  1  sticky flag: read or release attempted while rd_ready=0.

## Operation
- State: full[1:0], wr_bank and rd_bank pointers. Combinational outputs: wr_ready = !full[wr_bank]; rd_ready = full[rd_bank]; level = full[0]+full[1].
- Physical RAM address is {bank, addr}. Memory contents are not reset.
- Accepted write: wr_en & wr_ready. Writes mem[{wr_bank,wr_addr}].
- Rejected write: wr_en & !wr_ready. Memory is unchanged; err_wr is set.
- Accepted commit: wr_commit & wr_ready. Sets full[wr_bank] and toggles wr_bank.
  - A write in the same cycle lands in the committed bank before the swap.
- Rejected commit: wr_commit & !wr_ready. Ignored; err_wr is set.
- Accepted read: rd_en & rd_ready. Reads mem[{rd_bank,rd_addr}].
- Rejected read: rd_en & !rd_ready. No read is issued; err_rd is set; no rd_valid pulse.
- Accepted release: rd_release & rd_ready. Clears full[rd_bank] and toggles rd_bank.
  - A read in the same cycle uses the released bank.
- Commit and release in the same cycle: both take effect. They always target different banks, because a writable bank is empty and a readable bank is full.
- Read/write same-word collision cannot occur under legal use. If it is forced (e.g. err flags ignored), read data is don't-care.
- err_wr and err_rd clear only on reset.
- Arithmetic: bank pointers toggle modulo 2; level saturates naturally at 2 (both banks full, wr_ready=0).

## Timing
- Reset values: rd_data=0, rd_valid=0, full=00, wr_bank=0, rd_bank=0, level=0, wr_ready=1, rd_ready=0, err_wr=0, err_rd=0.
- Reset is asynchronous on assertion and takes effect mid-operation. The in-flight read pipeline is discarded: rd_valid=0 on the first cycle after deassertion.
- Write: data is visible to reads issued on the next cycle or later, after the commit.
- Read latency RD_LAT=1: rd_data and rd_valid are registered on the edge after an accepted rd_en.
- Read latency RD_LAT=2: an additional output register delays both by one more cycle.
- rd_valid is a one-cycle pulse per accepted read. Back-to-back reads give one result every cycle.
- rd_data holds its last value when there is no new read.
- Commit/release: flags and pointers update on the same edge; wr_ready, rd_ready and level reflect the change in the next cycle.
- A bank committed at edge N is readable (rd_ready=1) from cycle N+1.

## Test plan
- Reset: assert rst_n=0 mid-stream with reads in flight -> all outputs at their reset values; rd_valid=0 after release of reset.
- Fill and drain, RD_LAT=1:
  - Stimulus: write addr 0..1023 with data 0xA000_0000+addr into bank 0, commit, then read 0..1023.
  - Required: rd_valid one cycle after each rd_en with matching data; level 0->1; release -> level=0, rd_bank=1.
- Ping-pong overlap:
  - Stimulus: commit bank 0, then write bank 1 while reading bank 0; commit bank 1 and release bank 0 on the same edge.
  - Required: level stays 1, wr_bank=0, rd_bank=1, no errors.
- Both full:
  - Stimulus: commit twice without release.
  - Required: level=2, wr_ready=0; a further wr_en to addr 5 with 0xDEAD sets err_wr and bank contents are unchanged on readback.
- Empty read:
  - Stimulus: rd_en and rd_release with level=0.
  - Required: no rd_valid, pointers unchanged, err_rd=1 and remains 1.
- RD_LAT=2:
  - Stimulus: repeat the fill-and-drain scenario.
  - Required: rd_valid and data arrive exactly two cycles after rd_en; back-to-back reads at full rate with no gaps.
